// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Function : Round-robin, packet-locking arbiter sharing one UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_ack_err
);

  localparam int            IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int            CW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] C_PTR_RST  = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACK  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic             r_lock,     w_lock_nxt;
  logic [IW-1:0]    r_owner,    w_owner_nxt;
  logic [IW-1:0]    r_rr_ptr,   w_rr_ptr_nxt;
  logic [CW-1:0]    r_cnt,      w_cnt_nxt;
  logic [7:0]       r_tx_data,  w_tx_data_nxt;
  logic             r_tx_start, w_tx_start_nxt;
  logic [N_REQ-1:0] r_grant,    w_grant_nxt;
  logic             r_ack_err,  w_ack_err_nxt;

  logic             w_rr_found;
  logic [IW-1:0]    w_rr_idx;
  logic [IW-1:0]    w_sel_idx;
  logic [N_REQ-1:0] w_sel_onehot;
  logic [N_REQ-1:0] w_owner_onehot;
  logic [7:0]       w_sel_byte;
  logic             w_sel_last;
  logic             w_ready_en;
  logic             w_accept;

  // First valid requester after the last packet-completing one, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_rr_found && i_req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IW'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    w_sel_idx      = r_lock ? r_owner : w_rr_idx;
    w_sel_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
    w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
    w_sel_byte     = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel_idx == IW'(i)) w_sel_byte = i_req_data[8*i +: 8];
    end
    w_sel_last  = |(w_sel_onehot & i_req_last);
    // A locked owner is offered the slot even while it has nothing valid.
    w_ready_en  = (r_state == S_IDLE) && !i_tx_busy && rst_n && (r_lock || w_rr_found);
    o_req_ready = w_ready_en ? w_sel_onehot : '0;
    w_accept    = |(o_req_ready & i_req_valid);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_nxt     = r_lock;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_grant_nxt    = r_grant;
    w_ack_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tx_data_nxt  = w_sel_byte;
          w_tx_start_nxt = 1'b1;
          w_grant_nxt    = w_sel_onehot;
          w_cnt_nxt      = '0;
          w_owner_nxt    = w_sel_idx;
          w_state_nxt    = S_WAIT_ACK;
          if (w_sel_last) begin
            w_lock_nxt   = 1'b0;
            w_rr_ptr_nxt = w_sel_idx;
          end else begin
            w_lock_nxt   = 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        if (i_tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
          w_cnt_nxt   = r_cnt + 1'b1;
        end else if (r_cnt == C_CNT_LAST) begin
          w_ack_err_nxt = 1'b1;
          w_lock_nxt    = 1'b0;
          w_rr_ptr_nxt  = r_owner;
          w_grant_nxt   = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = r_lock ? w_owner_onehot : '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lock     <= 1'b0;
      r_owner    <= '0;
      r_rr_ptr   <= C_PTR_RST;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_grant    <= '0;
      r_ack_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock     <= w_lock_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_grant    <= w_grant_nxt;
      r_ack_err  <= w_ack_err_nxt;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_grant    = r_grant;
  assign o_ack_err  = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Bench for uart_tx_arbiter: requester sources, a transmitter model and a
// transaction-level reference model checked against the DUT every cycle.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int TO       = 4;
  localparam int BUSY_LEN = 10;

  logic           clk         = 1'b0;
  logic           rst_n       = 1'b0;
  logic [N-1:0]   i_req_valid = '0;
  logic [8*N-1:0] i_req_data  = '0;
  logic [N-1:0]   i_req_last  = '0;
  logic           i_tx_busy   = 1'b0;
  logic [N-1:0]   o_req_ready;
  logic [N-1:0]   o_grant;
  logic [7:0]     o_tx_data;
  logic           o_tx_start;
  logic           o_ack_err;

  uart_tx_arbiter #(.N_REQ(N), .ACK_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req_valid(i_req_valid),
    .i_req_data (i_req_data),
    .i_req_last (i_req_last),
    .o_req_ready(o_req_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy),
    .o_grant    (o_grant),
    .o_ack_err  (o_ack_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requester sources (ring buffers of {last, byte}) -------
  logic [8:0]   sb [N][32];
  int           sh [N];
  int           sc [N];
  logic [N-1:0] hold = '0;

  task automatic push(input int lane, input logic [7:0] d, input logic last);
    sb[lane][(sh[lane] + sc[lane]) % 32] = {last, d};
    sc[lane]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      i_req_valid[i]       = (sc[i] > 0) && !hold[i];
      i_req_data[8*i +: 8] = (sc[i] > 0) ? sb[i][sh[i]][7:0] : 8'h00;
      i_req_last[i]        = (sc[i] > 0) ? sb[i][sh[i]][8] : 1'b0;
    end
  endtask

  // ---------------- transmitter model -------------------------------------
  logic x_arm   = 1'b0;
  int   x_left  = 0;
  logic x_busy  = 1'b0;
  logic x_en    = 1'b1;
  logic x_force = 1'b0;
  logic x_rand  = 1'b0;

  task automatic cycle_rest();
    logic [N-1:0] hs;
    logic         edge_rst;
    hs = o_req_ready & i_req_valid;
    @(posedge clk);
    edge_rst = rst_n;
    #1;
    if (!rst_n) begin
      x_arm = 1'b0; x_left = 0; x_busy = 1'b0;
    end else begin
      if (x_arm) begin
        x_busy = 1'b1; x_left = BUSY_LEN - 1; x_arm = 1'b0;
      end else if (x_left > 0) begin
        x_left--;
      end else begin
        x_busy = 1'b0;
      end
      if (o_tx_start && (x_rand ? ($urandom_range(0, 5) != 0) : x_en)) x_arm = 1'b1;
    end
    i_tx_busy = x_busy | x_force;
    if (edge_rst) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          sh[i] = (sh[i] + 1) % 32;
          sc[i]--;
        end
      end
    end
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    cycle_rest();
  endtask

  // ---------------- reference model ---------------------------------------
  logic         m_pending = 1'b0;
  logic         m_acked   = 1'b0;
  logic         m_lock    = 1'b0;
  logic         m_start   = 1'b0;
  logic         m_err     = 1'b0;
  int           m_rr      = N - 1;
  int           m_owner   = 0;
  int           m_edges   = 0;
  logic [7:0]   m_txd     = 8'h00;
  logic [N-1:0] m_grant   = '0;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rr_pick(input int rr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(rr + k) % N]) return onehot((rr + k) % N);
    return '0;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    if (m_pending || i_tx_busy || !rst_n) return '0;
    if (m_lock) return onehot(m_owner);
    return rr_pick(m_rr, i_req_valid);
  endfunction

  function automatic int acc_lane();
    logic [N-1:0] h;
    h = exp_ready() & i_req_valid;
    for (int i = 0; i < N; i++) if (h[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] lane_byte(input int i);
    return i_req_data[8*i +: 8];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0; m_acked <= 1'b0; m_lock <= 1'b0; m_start <= 1'b0;
      m_err <= 1'b0; m_rr <= N - 1; m_owner <= 0; m_edges <= 0;
      m_txd <= 8'h00; m_grant <= '0;
    end else begin
      m_start <= 1'b0;
      m_err   <= 1'b0;
      if (!m_pending) begin
        if (acc_lane() >= 0) begin
          m_txd     <= lane_byte(acc_lane());
          m_start   <= 1'b1;
          m_grant   <= onehot(acc_lane());
          m_pending <= 1'b1;
          m_acked   <= 1'b0;
          m_edges   <= 0;
          m_owner   <= acc_lane();
          if (i_req_last[acc_lane()]) begin
            m_lock <= 1'b0;
            m_rr   <= acc_lane();
          end else begin
            m_lock <= 1'b1;
          end
        end
      end else if (!m_acked) begin
        if (i_tx_busy) begin
          m_acked <= 1'b1;
        end else if (m_edges + 1 == TO) begin
          m_err <= 1'b1; m_lock <= 1'b0; m_rr <= m_owner;
          m_grant <= '0; m_pending <= 1'b0;
        end else begin
          m_edges <= m_edges + 1;
        end
      end else if (!i_tx_busy) begin
        m_pending <= 1'b0;
        if (!m_lock) m_grant <= '0;
      end
    end
  end

  // ---------------- per-cycle compare and start/err log -------------------
  logic [7:0]   log_d [$];
  logic [N-1:0] log_g [$];
  int           log_c [$];
  int           err_c [$];

  always @(negedge clk) begin
    cyc++;
    if (o_tx_start) begin
      log_d.push_back(o_tx_data);
      log_g.push_back(o_grant);
      log_c.push_back(cyc);
    end
    if (o_ack_err) err_c.push_back(cyc);
    chk("req_ready", o_req_ready, exp_ready());
    chk("tx_start",  o_tx_start,  m_start);
    chk("tx_data",   o_tx_data,   m_txd);
    chk("grant",     o_grant,     m_grant);
    chk("ack_err",   o_ack_err,   m_err);
  end

  task automatic wait_log(input int n, input int budget, input string what);
    int k;
    k = 0;
    while (log_d.size() < n && k < budget) begin
      cycle();
      k++;
    end
    checks++;
    if (log_d.size() < n) begin
      errors++;
      $display("FAIL %s: only %0d bytes started, expected %0d", what, log_d.size(), n);
    end
  endtask

  task automatic chk_log(input int idx, input logic [7:0] d, input logic [N-1:0] g, input string name);
    if (idx >= log_d.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: byte %0d never started, expected data %0h", name, idx, d);
    end else begin
      chk({name, "_data"},  log_d[idx], d);
      chk({name, "_grant"}, log_g[idx], g);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int e;
    int k;
    for (int i = 0; i < N; i++) begin
      sh[i] = 0;
      sc[i] = 0;
    end

    // Reset with every requester valid, then round-robin of single-byte packets.
    push(0, 8'h10, 1'b1); push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    drive();
    repeat (3) cycle();
    chk("rst_ready",   o_req_ready, 0);
    chk("rst_start",   o_tx_start,  0);
    chk("rst_grant",   o_grant,     0);
    chk("rst_ack_err", o_ack_err,   0);
    chk("rst_tx_data", o_tx_data,   0);
    @(negedge clk); rst_n = 1'b1; #1; cycle_rest();
    wait_log(5, 200, "rr");
    chk_log(0, 8'h10, 4'b0001, "rr0");
    chk_log(1, 8'h11, 4'b0010, "rr1");
    chk_log(2, 8'h12, 4'b0100, "rr2");
    chk_log(3, 8'h13, 4'b1000, "rr3");
    chk_log(4, 8'h10, 4'b0001, "rr4");

    // Packet lock: requester 2 keeps the grant while requester 1 waits.
    repeat (15) cycle();
    b = log_d.size();
    push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1); drive();
    wait_log(b + 1, 40, "lock_first");
    push(1, 8'h51, 1'b1); drive();
    wait_log(b + 4, 200, "lock");
    chk_log(b,     8'hA0, 4'b0100, "lock0");
    chk_log(b + 1, 8'hA1, 4'b0100, "lock1");
    chk_log(b + 2, 8'hA2, 4'b0100, "lock2");
    chk_log(b + 3, 8'h51, 4'b0010, "lock3");

    // Locked owner drops valid for 20 cycles mid-packet.
    repeat (15) cycle();
    b = log_d.size();
    push(3, 8'hB0, 1'b0); drive();
    wait_log(b + 1, 40, "gap_first");
    hold[3] = 1'b1;
    push(3, 8'hB1, 1'b0); push(3, 8'hB2, 1'b1);
    push(0, 8'h60, 1'b1); push(1, 8'h61, 1'b1); push(2, 8'h62, 1'b1); drive();
    repeat (20) cycle();
    chk("gap_no_accept", log_d.size(), b + 1);
    chk("gap_ready", o_req_ready, 4'b1000);
    hold[3] = 1'b0; drive();
    wait_log(b + 6, 300, "gap");
    chk_log(b + 1, 8'hB1, 4'b1000, "gap1");
    chk_log(b + 2, 8'hB2, 4'b1000, "gap2");
    chk_log(b + 3, 8'h60, 4'b0001, "gap3");
    chk_log(b + 4, 8'h61, 4'b0010, "gap4");
    chk_log(b + 5, 8'h62, 4'b0100, "gap5");

    // Handshake timeout on a mid-packet byte.
    repeat (15) cycle();
    b = log_d.size();
    e = err_c.size();
    x_en = 1'b0;
    push(1, 8'hC0, 1'b0); drive();
    wait_log(b + 1, 40, "to_first");
    x_en = 1'b1;
    push(0, 8'h70, 1'b1); push(2, 8'h72, 1'b1); drive();
    k = 0;
    while (err_c.size() == e && k < 20) begin
      cycle();
      k++;
    end
    chk("to_pulses", err_c.size(), e + 1);
    if (err_c.size() > e) chk("to_delay", err_c[e] - log_c[b], 4);
    wait_log(b + 3, 300, "to");
    chk_log(b + 1, 8'h72, 4'b0100, "to1");
    chk_log(b + 2, 8'h70, 4'b0001, "to2");

    // Transmitter already busy while idle: nothing accepted until it falls.
    repeat (15) cycle();
    b = log_d.size();
    x_force = 1'b1;
    cycle();
    push(0, 8'h80, 1'b1); drive();
    repeat (8) cycle();
    chk("busy_no_accept", log_d.size(), b);
    chk("busy_ready", o_req_ready, 0);
    x_force = 1'b0;
    wait_log(b + 1, 40, "busy");
    chk_log(b, 8'h80, 4'b0001, "busy0");

    // Reset during the frame of a locked packet.
    repeat (15) cycle();
    b = log_d.size();
    push(2, 8'hD0, 1'b0); push(2, 8'hD1, 1'b1); drive();
    wait_log(b + 1, 40, "mid_first");
    push(0, 8'h90, 1'b1); push(1, 8'h91, 1'b1); drive();
    repeat (4) cycle();
    @(negedge clk); #2; rst_n = 1'b0; cycle_rest();
    chk("mid_rst_grant", o_grant, 0);
    chk("mid_rst_ready", o_req_ready, 0);
    cycle();
    @(negedge clk); rst_n = 1'b1; #1; cycle_rest();
    wait_log(b + 2, 60, "mid");
    chk_log(b + 1, 8'h90, 4'b0001, "mid1");

    // Randomized traffic with occasional missing acknowledges.
    repeat (60) cycle();
    x_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (sc[i] < 4 && $urandom_range(0, 3) == 0)
          push(i, 8'($urandom), ($urandom_range(0, 2) != 0));
        if (!hold[i] && $urandom_range(0, 15) == 0) hold[i] = 1'b1;
        else if (hold[i] && $urandom_range(0, 3) == 0) hold[i] = 1'b0;
      end
      drive();
      cycle();
    end
    x_rand = 1'b0;
    hold   = '0;
    drive();
    repeat (400) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
